debug_mem_access_engine: RTL and testbench
==========================================

Name: debug_mem_access_engine

Overview:
- Downstream consumer of the debug-slave sysclk outputs: jdo plus the take_action/take_no_action ocimem strobes.
- Turns host debug commands into single-word Avalon-MM master reads and writes against the on-chip debug memory region.
- Returns MonDReg, monitor_ready and monitor_error, which feed back to the debug-slave TCK side for readout.
- Sits between the debug-slave wrapper and the CPU's debug ROM/RAM interconnect.

Parameters:
- ADDR_W, 9, word-address width of the debug memory window; legal range 1..17.
- TIMEOUT, 255, consecutive waitrequest cycles before a transfer is abandoned; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  command/data word from the debug slave.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, optionally read.
- take_action_ocimem_b  in  1  one-cycle strobe: write data word.
- take_no_action_ocimem_a  in  1  one-cycle strobe: increment address, then read.
- avm_address  out  ADDR_W+2  byte address, {addr, 2'b00}.
- avm_read  out  1  Avalon read request.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  valid in the cycle avm_read=1 and avm_waitrequest=0.
- MonDReg  out  32  last read or written data word.
- monitor_ready  out  1  last transfer complete.
- monitor_error  out  1  last transfer timed out.
- busy  out  1  transfer in flight.

Behaviour:
- Reset values: addr=0, MonDReg=0, monitor_ready=0, monitor_error=0, avm_read=0, avm_write=0, avm_writedata=0, busy=0, state=IDLE, timeout counter=0.
- Reset is honoured mid-transfer: the request drops immediately and no completion is reported.
- States:
  - IDLE: accept a strobe.
  - RD: hold avm_read and avm_address until avm_waitrequest=0.
  - WR: hold avm_write, avm_writedata and avm_address until avm_waitrequest=0.
- Strobe priority when several fire in one cycle: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a. Lower-priority strobes that cycle are discarded.
- take_action_ocimem_a:
  - addr <= jdo[17+ADDR_W-1:17].
  - If jdo[34]=1, go to RD at the new addr; otherwise stay IDLE with monitor_ready=1.
- take_action_ocimem_b: avm_writedata <= jdo[34:3] and MonDReg <= jdo[34:3]; go to WR at the current addr.
- take_no_action_ocimem_a: addr <= addr+1 (wraps modulo 2^ADDR_W); go to RD at the incremented addr.
- Any accepted strobe that starts a transfer:
  - clears monitor_ready and monitor_error;
  - sets busy;
  - loads the timeout counter with 0.
- Strobes arriving while busy=1 are ignored; addr, data and state are unaffected.
- Latency: strobe at cycle N -> request asserted at N+1. With no stall (waitrequest=0 at N+1), completion is visible at N+2 (monitor_ready=1, busy=0, MonDReg updated on a read).
- Each stall cycle adds one cycle of latency.
- RD completion: MonDReg <= avm_readdata; return to IDLE; addr unchanged.
- WR completion: addr <= addr+1 (wraps); return to IDLE.
- Timeout:
  - The counter increments each cycle that waitrequest=1 in RD or WR.
  - When it reaches TIMEOUT-1 with waitrequest still 1, the request drops the next cycle.
  - On timeout: monitor_error=1, monitor_ready=1, busy=0, MonDReg unchanged, addr unchanged (including for a write).
- avm_read and avm_write are never asserted together.
- avm_read, avm_write and avm_address change only on entry to or exit from RD/WR, never while waitrequest=1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RD, WR};
  - jdo field constants: JDO_ADDR_LSB=17, JDO_RDNOW_BIT=34, JDO_WDATA_LSB=3, JDO_WDATA_MSB=34.
- One sub-module, debug_mem_timeout_ctr: loadable saturating counter with `expired` output, width $clog2(TIMEOUT+1).

Test Plan:
- ocimem_a with jdo[25:17]=9'h010 and jdo[34]=1; slave returns 32'hDEADBEEF, no stall -> avm_address=11'h040 at N+1; MonDReg=32'hDEADBEEF and monitor_ready=1 at N+2.
- ocimem_b with jdo[34:3]=32'h12345678 at addr 9'h1FF, 3 stall cycles -> avm_write held 4 cycles with stable address/data; then addr wraps to 0 and monitor_ready=1.
- Three back-to-back no_action_ocimem_a from addr 5, each issued after ready -> reads of byte addresses 0x18, 0x1C, 0x20.
- Waitrequest held high with TIMEOUT=4 -> request drops after 4 cycles; monitor_error=1, monitor_ready=1, MonDReg unchanged; the next strobe clears monitor_error.
- ocimem_a and ocimem_b in the same cycle -> only the address load/read occurs. A strobe during a stalled read is ignored, and addr is unchanged afterwards.
- reset asserted mid-RD with waitrequest=1 -> avm_read=0 and all outputs at reset values in the same cycle; after reset release, no spurious completion.

Source files
------------

// File: rtl/debug_mem_access_engine_pkg.sv
// Shared types and jdo field layout for the debug memory access engine.
package debug_mem_access_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RDNOW_BIT = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;

    // Extract the 32-bit write data word carried by an ocimem_b command.
    function automatic logic [31:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    endfunction

endpackage

// File: rtl/debug_mem_timeout_ctr.sv
// Loadable saturating stall counter; `expired` flags that the current stall
// cycle is the last one allowed before the transfer is abandoned.
module debug_mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             expired_q;
    logic             expired_d;

    // Next count: clear on load, count stall cycles up to LIMIT, then hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (inc && (count_q < LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        expired_d = (count_d == LIMIT);
    end

    // Counter and registered expiry flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= (LIMIT == CNT_W'(0));
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/debug_mem_access_engine.sv
// Turns debug-slave ocimem strobes into single-word Avalon-MM reads/writes
// on the debug memory window and reports the result back as MonDReg plus
// ready/error status.
module debug_mem_access_engine
    import debug_mem_access_engine_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         mon_q, mon_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                ctr_load;
    logic                ctr_inc;
    logic                ctr_expired;
    logic                jdo_unused;

    // Bits of jdo that carry no field for this engine.
    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    debug_mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .load    (ctr_load),
        .inc     (ctr_inc),
        .expired (ctr_expired)
    );

    // Next-state logic: strobes are only accepted in IDLE (busy low); a
    // transfer ends on the first non-stalled cycle or when stalls run out.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mon_d    = mon_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ready_d  = ready_q;
        error_d  = error_q;
        busy_d   = busy_q;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (jdo[JDO_RDNOW_BIT]) begin
                        state_d  = RD;
                        rd_d     = 1'b1;
                        busy_d   = 1'b1;
                        ready_d  = 1'b0;
                        error_d  = 1'b0;
                        ctr_load = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d  = jdo_wdata(jdo);
                    mon_d    = jdo_wdata(jdo);
                    state_d  = WR;
                    wr_d     = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    error_d  = 1'b0;
                    ctr_load = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    state_d  = RD;
                    rd_d     = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    error_d  = 1'b0;
                    ctr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (!avm_waitrequest) begin
                    mon_d   = avm_readdata;
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (ctr_expired) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            WR: begin
                if (!avm_waitrequest) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (ctr_expired) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mon_q   <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign avm_address    = {addr_q, 2'b00};
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign MonDReg        = mon_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_debug_mem_access_engine.sv
// Scoreboard bench: the stimulus process predicts bus requests and
// completions from a word-level model and queues them; an independent
// monitor pops and compares whenever the DUT presents them.
module tb_debug_mem_access_engine;

    localparam int AW = 9;
    localparam int TO = 4;
    localparam int NWORDS = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = 38'h0;
    logic        ta_a = 1'b0;
    logic        ta_b = 1'b0;
    logic        tn_a = 1'b0;
    logic [10:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    debug_mem_access_engine #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_waitrequest         (avm_waitrequest),
        .avm_readdata            (avm_readdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [31:0] data;
        int          cyc;
    } req_t;

    typedef struct {
        logic [31:0] mon;
        bit          err;
        int          cyc;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];

    logic [31:0] slv_mem[NWORDS];
    logic [31:0] ref_mem[NWORDS];
    int          stall_plan = 0;
    int          scyc = 0;
    int          model_addr = 0;
    logic [31:0] model_mon = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [8:0] addr, input bit rd);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[25:17] = addr;
        j[34] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[34:3] = data;
        return j;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_write"}, avm_write, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, monitor_ready, 0);
        chk({tag, "_error"}, monitor_error, 0);
        chk({tag, "_mondreg"}, MonDReg, 0);
        chk({tag, "_address"}, avm_address, 0);
        chk({tag, "_writedata"}, avm_writedata, 0);
    endtask

    // Slave: stalls each request for stall_plan cycles, then serves memory.
    initial begin
        forever begin
            @(negedge clk);
            if (avm_read || avm_write) begin
                avm_waitrequest = (scyc < stall_plan);
                scyc++;
                if (avm_read && !avm_waitrequest)
                    avm_readdata = slv_mem[avm_address[10:2]];
                else
                    avm_readdata = $urandom;
                if (avm_write && !avm_waitrequest)
                    slv_mem[avm_address[10:2]] = avm_writedata;
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata = $urandom;
                scyc = 0;
            end
        end
    end

    // Monitor: compares request starts, held requests and completions.
    initial begin
        bit          prev_act = 0;
        bit          prev_busy = 0;
        bit          prev_wr = 0;
        logic [10:0] prev_addr = 0;
        logic [31:0] prev_data = 0;
        req_t        r;
        cmp_t        m;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_act = 0;
                prev_busy = 0;
            end else begin
                chk("rd_wr_exclusive", avm_read && avm_write, 0);
                chk("byteenable", avm_byteenable, 4'hF);
                if ((avm_read || avm_write) && !prev_act) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request actual=present required=none (t=%0t)", $time);
                    end else begin
                        r = req_q.pop_front();
                        checks++;
                        chk("req_is_write", avm_write, r.wr);
                        chk("req_address", avm_address, r.addr);
                        chk("req_cycle", cyc, r.cyc);
                        if (r.wr) chk("req_wdata", avm_writedata, r.data);
                    end
                end else if ((avm_read || avm_write) && prev_act) begin
                    chk("hold_is_write", avm_write, prev_wr);
                    chk("hold_address", avm_address, prev_addr);
                    if (prev_wr) chk("hold_wdata", avm_writedata, prev_data);
                end
                if (prev_busy && !busy) begin
                    if (cmp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_completion actual=present required=none (t=%0t)", $time);
                    end else begin
                        m = cmp_q.pop_front();
                        chk("done_ready", monitor_ready, 1);
                        chk("done_error", monitor_error, m.err);
                        chk("done_mondreg", MonDReg, m.mon);
                        chk("done_cycle", cyc, m.cyc);
                        chk("done_req_low", avm_read || avm_write, 0);
                    end
                end
                prev_act = avm_read || avm_write;
                prev_busy = busy;
                prev_wr = avm_write;
                prev_addr = avm_address;
                prev_data = avm_writedata;
            end
        end
    end

    // Issue one strobe cycle, predict its outcome, then wait for idle.
    task automatic do_cmd(input bit a, input bit b, input bit n, input logic [37:0] j,
                          input int stall, input bit intrude);
        bit   start = 0;
        bit   is_wr = 0;
        bit   to;
        int   c0;
        req_t r;
        cmp_t m;
        @(negedge clk);
        c0 = cyc;
        to = (stall >= TO);
        if (a) begin
            model_addr = int'(j[25:17]);
            start = j[34];
        end else if (b) begin
            start = 1;
            is_wr = 1;
            model_mon = j[34:3];
        end else if (n) begin
            model_addr = (model_addr + 1) % NWORDS;
            start = 1;
        end
        if (start) begin
            r.wr = is_wr;
            r.addr = 11'(model_addr * 4);
            r.data = j[34:3];
            r.cyc = c0 + 1;
            req_q.push_back(r);
            if (!is_wr && !to) model_mon = ref_mem[model_addr];
            if (is_wr && !to) ref_mem[model_addr] = j[34:3];
            m.mon = model_mon;
            m.err = to;
            m.cyc = to ? (c0 + 1 + TO) : (c0 + 2 + stall);
            cmp_q.push_back(m);
            if (is_wr && !to) model_addr = (model_addr + 1) % NWORDS;
        end
        stall_plan = stall;
        jdo = j;
        ta_a = a;
        ta_b = b;
        tn_a = n;
        @(negedge clk);
        ta_a = 0;
        ta_b = 0;
        tn_a = 0;
        jdo = {6'($urandom), 32'($urandom)};
        if (start && intrude) begin
            ta_a = 1'($urandom_range(0, 1));
            ta_b = 1'($urandom_range(0, 1));
            tn_a = !(ta_a || ta_b) ? 1'b1 : 1'($urandom_range(0, 1));
            jdo[34] = 1'b1;
            @(negedge clk);
            ta_a = 0;
            ta_b = 0;
            tn_a = 0;
        end
        if (a && !start) begin
            chk("load_only_ready", monitor_ready, 1);
            chk("load_only_busy", busy, 0);
        end
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        chk("busy_bound", busy, 0);
    endtask

    // Reset during a stalled read: request drops at once, no completion later.
    task automatic reset_mid_read();
        req_t r;
        stall_plan = 50;
        @(negedge clk);
        model_addr = 7;
        r.wr = 0;
        r.addr = 11'(7 * 4);
        r.data = 0;
        r.cyc = cyc + 1;
        req_q.push_back(r);
        jdo = jdo_a(9'h007, 1);
        ta_a = 1;
        @(negedge clk);
        ta_a = 0;
        @(negedge clk);
        #1 reset = 1;
        #1 check_reset_vals("mid_rd_reset");
        req_q.delete();
        cmp_q.delete();
        model_addr = 0;
        model_mon = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        repeat (6) @(negedge clk);
        chk("post_reset_ready", monitor_ready, 0);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_read", avm_read, 0);
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < NWORDS; i++) begin
            v = $urandom;
            slv_mem[i] = v;
            ref_mem[i] = v;
        end
        slv_mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check_reset_vals("init");
        reset = 0;
        model_addr = 0;
        model_mon = 32'h0;

        // Load address 0x010 and read it back without stalls.
        do_cmd(1, 0, 0, jdo_a(9'h010, 1), 0, 0);
        // Write at the top of the window with 3 stalls, then read the wrapped+1 word.
        do_cmd(1, 0, 0, jdo_a(9'h1FF, 0), 0, 0);
        do_cmd(0, 1, 0, jdo_b(32'h12345678), 3, 0);
        do_cmd(0, 0, 1, 38'h0, 0, 0);
        // Increment-and-read three times from address 5.
        do_cmd(1, 0, 0, jdo_a(9'h005, 0), 0, 0);
        for (int i = 0; i < 3; i++) do_cmd(0, 0, 1, 38'h0, i, 0);
        // Timeout on a read, then a clean read clears the error.
        do_cmd(1, 0, 0, jdo_a(9'h033, 1), 10, 0);
        do_cmd(0, 0, 1, 38'h0, 0, 0);
        // Timeout on a write leaves the address alone.
        do_cmd(0, 1, 0, jdo_b(32'hCAFEF00D), 6, 0);
        do_cmd(0, 0, 1, 38'h0, 1, 0);
        // Simultaneous a+b: only the address load/read happens.
        do_cmd(1, 1, 0, jdo_a(9'h0AA, 1), 1, 0);
        // Strobes during a stalled read are ignored.
        do_cmd(0, 0, 1, 38'h0, 3, 1);
        do_cmd(0, 0, 1, 38'h0, 0, 0);
        // Reset mid-transfer, then resume from address 0.
        reset_mid_read();
        do_cmd(0, 0, 1, 38'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            int s;
            s = $urandom_range(0, 5);
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {6'($urandom), 32'($urandom)}, s, (s >= 1) && ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("req_queue_drained", req_q.size(), 0);
        chk("cmp_queue_drained", cmp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
